// File: rtl/ppu_quant.sv
// ppu_quant: post-processing quantizer behind the matrix-multiply controller.
//
// Each i_start pulse is followed by a 16-row burst of INT24 accumulator
// vectors. INT8 and INT4 first run a MAX pass over every tile to find the
// global max-abs. A CALC pass then requantizes every row with one
// power-of-two shift. INT4_VSQ skips the MAX pass and derives the shift per
// row from that row's own max-abs.
//
// Ports:
//   i_clk       clock
//   i_rst       synchronous, active-high reset
//   i_start     burst start pulse; row r arrives r+1 cycles later
//   i_mode      `INT8 / `INT4 / `INT4_VSQ
//   i_acc_data  16 x INT24 signed, entry k at [k*24 +: 24]
//   o_valid     quantized row valid (two cycles after the row arrives)
//   o_data      16 x 8-bit signed results (INT4 sign-extended)
//   o_scale     {3'b0, shift} applied to this row
//   o_addr      tile_idx*16 + row
//   o_done      pulses together with the last CALC row
//   o_overrun   sticky: i_start seen while a burst was active
//
// Optional build macro PPU_RELU_EN: negative entries are clamped to zero
// before max tracking and quantization.

`ifndef INT8
`define INT8 2'b00
`endif
`ifndef INT4
`define INT4 2'b01
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2'b10
`endif

module ppu_quant #(
  parameter int NUM_TILES = 1024
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [1:0]   i_mode,
  input  logic [383:0] i_acc_data,
  output logic         o_valid,
  output logic [127:0] o_data,
  output logic [7:0]   o_scale,
  output logic [13:0]  o_addr,
  output logic         o_done,
  output logic         o_overrun
);

  localparam int ROWS = 16;
  localparam int TW   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MAX, S_CALC} state_t;

  state_t           state;
  logic   [1:0]     mode_q;
  logic             burst_active;
  logic   [3:0]     burst_cnt;
  logic   [TW-1:0]  tile_idx;
  logic   [22:0]    max_abs;
  logic   [4:0]     g_shift;

  logic   [383:0]   acc_eff;
  logic   [22:0]    row_max;
  logic   [22:0]    max_next;
  logic             last_row;
  logic             last_tile;
  logic             row_calc;

  logic             s1_valid;
  logic             s1_last;
  logic   [383:0]   s1_acc;
  logic   [22:0]    s1_rmax;
  logic   [13:0]    s1_addr;
  logic             s1_int8;
  logic             s1_vsq;

  logic   [4:0]     s2_shift;
  logic   [127:0]   q;

  // |v| on 23 bits; -2^23 has no positive INT24 counterpart and saturates.
  function automatic logic [22:0] abs_sat(input logic [23:0] v);
    logic [23:0] n;
    n = -v;
    if (!v[23])              return v[22:0];
    else if (v == 24'h800000) return 23'h7F_FFFF;
    else                      return n[22:0];
  endfunction

  // Smallest shift that brings m into the target magnitude (7 or 3 bits).
  function automatic logic [4:0] shift_of(input logic [22:0] m, input logic int8);
    logic [4:0] len;
    logic [4:0] tgt;
    len = '0;
    for (int i = 0; i < 23; i++)
      if (m[i]) len = 5'(i + 1);
    tgt = int8 ? 5'd7 : 5'd3;
    return (len > tgt) ? len - tgt : 5'd0;
  endfunction

  // NOTE: every variable written in an always_comb gets a default on entry,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    acc_eff = i_acc_data;
`ifdef PPU_RELU_EN
    for (int k = 0; k < ROWS; k++)
      if (i_acc_data[k*24 + 23]) acc_eff[k*24 +: 24] = '0;
`endif
  end

  always_comb begin
    row_max = '0;
    for (int k = 0; k < ROWS; k++)
      if (abs_sat(acc_eff[k*24 +: 24]) > row_max) row_max = abs_sat(acc_eff[k*24 +: 24]);
  end

  assign max_next  = (row_max > max_abs) ? row_max : max_abs;
  assign last_row  = (burst_cnt == 4'(ROWS - 1));
  assign last_tile = (tile_idx == TW'(NUM_TILES - 1));
  assign row_calc  = burst_active && (state == S_CALC);

  // Control: burst sequencing, FSM, max tracking and stage-1 qualifiers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      mode_q       <= 2'b00;
      burst_active <= 1'b0;
      burst_cnt    <= '0;
      tile_idx     <= '0;
      max_abs      <= '0;
      g_shift      <= '0;
      o_overrun    <= 1'b0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
    end else begin
      if (i_start) begin
        if (burst_active) begin
          o_overrun <= 1'b1;
        end else begin
          burst_active <= 1'b1;
          burst_cnt    <= '0;
        end
      end
      if (burst_active) begin
        burst_cnt <= burst_cnt + 4'd1;
        if (last_row) burst_active <= 1'b0;
      end

      s1_valid <= row_calc;
      s1_last  <= row_calc && last_row && last_tile;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            mode_q   <= i_mode;
            max_abs  <= '0;
            tile_idx <= '0;
            state    <= (i_mode == `INT4_VSQ) ? S_CALC : S_MAX;
          end
        end
        S_MAX: begin
          if (burst_active) begin
            max_abs <= max_next;
            if (last_row) begin
              if (last_tile) begin
                g_shift  <= shift_of(max_next, mode_q == `INT8);
                tile_idx <= '0;
                state    <= S_CALC;
              end else begin
                tile_idx <= tile_idx + 1'b1;
              end
            end
          end
        end
        S_CALC: begin
          if (burst_active && last_row) begin
            if (last_tile) begin
              tile_idx <= '0;
              state    <= S_IDLE;
            end else begin
              tile_idx <= tile_idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1 datapath.
  // NOTE: pure datapath registers carry no reset; s1_valid qualifies them,
  // which keeps the reset net off 400+ flops.
  always_ff @(posedge i_clk) begin
    if (row_calc) begin
      s1_acc  <= acc_eff;
      s1_rmax <= row_max;
      s1_addr <= 14'({tile_idx, burst_cnt});
      s1_int8 <= (mode_q == `INT8);
      s1_vsq  <= (mode_q == `INT4_VSQ);
    end
  end

  // Stage 2: round-half-up, arithmetic shift, symmetric saturation.
  always_comb begin
    logic signed [24:0] a;
    logic signed [24:0] rnd;
    logic signed [24:0] r;
    logic signed [24:0] lim;
    s2_shift = s1_vsq ? shift_of(s1_rmax, 1'b0) : g_shift;
    rnd      = (s2_shift == 5'd0) ? 25'sd0 : (25'sd1 <<< (s2_shift - 5'd1));
    lim      = s1_int8 ? 25'sd127 : 25'sd7;
    q        = '0;
    a        = '0;
    r        = '0;
    for (int k = 0; k < ROWS; k++) begin
      a = {s1_acc[k*24 + 23], s1_acc[k*24 +: 24]};
      r = (a + rnd) >>> s2_shift;
      if (r > lim)       r = lim;
      else if (r < -lim) r = -lim;
      q[k*8 +: 8] = r[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_scale <= '0;
      o_addr  <= '0;
      o_done  <= 1'b0;
    end else begin
      o_valid <= s1_valid;
      o_data  <= s1_valid ? q : '0;
      o_scale <= s1_valid ? {3'b000, s2_shift} : 8'd0;
      o_addr  <= s1_valid ? s1_addr : 14'd0;
      o_done  <= s1_valid && s1_last;
    end
  end

endmodule

// File: tb/tb_ppu_quant.sv
// tb_ppu_quant: directed scoreboard bench for ppu_quant with NUM_TILES=2.
// The driver pushes hand-computed expected rows (data, scale, address, done
// flag, arrival cycle) into a queue; a negedge monitor pops and compares
// whenever o_valid is seen.

`ifndef INT8
`define INT8 2'b00
`endif
`ifndef INT4
`define INT4 2'b01
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2'b10
`endif

module tb_ppu_quant;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [1:0]   i_mode;
  logic [383:0] i_acc_data;
  logic         o_valid;
  logic [127:0] o_data;
  logic [7:0]   o_scale;
  logic [13:0]  o_addr;
  logic         o_done;
  logic         o_overrun;

  ppu_quant #(.NUM_TILES(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_acc_data (i_acc_data),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_scale    (o_scale),
    .o_addr     (o_addr),
    .o_done     (o_done),
    .o_overrun  (o_overrun)
  );

  typedef struct {
    logic [127:0] data;
    logic [7:0]   scale;
    logic [13:0]  addr;
    logic         done;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_valid = 0;
  int           cyc = 0;
  int           ent[16];
  int           qv[16];
  logic [383:0] row_acc[16];
  logic [127:0] row_exp[16];
  logic [7:0]   row_scale[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (o_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: addr %0d seen with no row expected", o_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data",    o_data,  e.data);
        check("scale",   128'(o_scale), 128'(e.scale));
        check("addr",    128'(o_addr),  128'(e.addr));
        check("done",    128'(o_done),  128'(e.done));
        check("latency", 128'(cyc),     128'(e.cyc));
      end
    end else if (o_done) begin
      check("stray_done", 128'(o_done), 128'd0);
    end
  end

  task automatic clear_ent();
    for (int k = 0; k < 16; k++) begin
      ent[k] = 0;
      qv[k]  = 0;
    end
  endtask

  task automatic set_row(input int r, input logic [7:0] sc);
    for (int k = 0; k < 16; k++) begin
      row_acc[r][k*24 +: 24] = 24'(ent[k]);
      row_exp[r][k*8 +: 8]   = 8'(qv[k]);
    end
    row_scale[r] = sc;
    clear_ent();
  endtask

  task automatic zero_rows();
    clear_ent();
    for (int r = 0; r < 16; r++) set_row(r, 8'd0);
  endtask

  // One burst: start pulse then 16 rows. glitch_row re-pulses i_start with
  // that row; rst_row asserts reset with that row and abandons the burst.
  task automatic burst(input bit push, input int tile, input bit last,
                       input int glitch_row, input int rst_row);
    exp_t e;
    @(negedge clk);
    i_start = 1'b1;
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      i_start    = (r == glitch_row);
      i_acc_data = row_acc[r];
      if (r == rst_row) begin
        rst = 1'b1;
        break;
      end
      if (push && (rst_row < 0 || r < rst_row - 1)) begin
        e.data  = row_exp[r];
        e.scale = row_scale[r];
        e.addr  = 14'(tile * 16 + r);
        e.done  = last && (r == 15);
        e.cyc   = cyc + 2;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    i_start    = 1'b0;
    i_acc_data = '0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    check(name, 128'(sb.size()), 128'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},   128'(o_valid),   128'd0);
    check({tag, "_data"},    o_data,          128'd0);
    check({tag, "_scale"},   128'(o_scale),   128'd0);
    check({tag, "_addr"},    128'(o_addr),    128'd0);
    check({tag, "_done"},    128'(o_done),    128'd0);
    check({tag, "_overrun"}, 128'(o_overrun), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv0;
    rst        = 1'b1;
    i_start    = 1'b0;
    i_mode     = `INT8;
    i_acc_data = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

`ifdef PPU_RELU_EN
    // MAX over {-5000, 200} with negatives clamped: max 200, shift 1.
    i_mode = `INT8;
    zero_rows();
    ent[0] = -5000; ent[1] = 200; set_row(0, 8'd0);
    nv0 = n_valid;
    burst(0, 0, 0, -1, -1);
    zero_rows();
    burst(0, 1, 0, -1, -1);
    check("relu_max_quiet", 128'(n_valid - nv0), 128'd0);
    for (int r = 0; r < 16; r++) begin
      ent[0] = -500; ent[1] = 200; ent[2] = 100; ent[3] = 255;
      qv[0]  = 0;    qv[1]  = 100; qv[2]  = 50;  qv[3]  = 127;
      set_row(r, 8'd1);
    end
    burst(1, 0, 0, -1, -1);
    burst(1, 1, 1, -1, -1);
    drain("relu_drain");
`else
    // INT8: one 1000 in the MAX pass -> shift 3.
    i_mode = `INT8;
    zero_rows();
    ent[0] = 1000; set_row(0, 8'd0);
    nv0 = n_valid;
    burst(0, 0, 0, -1, -1);
    zero_rows();
    burst(0, 1, 0, -1, -1);
    check("int8_max_quiet", 128'(n_valid - nv0), 128'd0);
    for (int r = 0; r < 16; r++) begin
      ent[0] = 1000; ent[1] = -1000; ent[2] = 1020; ent[3] = 3;
      ent[4] = -12;  ent[5] = -13;   ent[6] = -4;   ent[7] = -20;
      ent[8] = 8388607; ent[9] = -8388608; ent[10] = r;
      qv[0]  = 125;  qv[1]  = -125;  qv[2]  = 127;  qv[3]  = 0;
      qv[4]  = -1;   qv[5]  = -2;    qv[6]  = 0;    qv[7]  = -2;
      qv[8]  = 127;  qv[9]  = -127;  qv[10] = (r + 4) / 8;
      set_row(r, 8'd3);
    end
    burst(1, 0, 0, -1, -1);
    burst(1, 1, 1, -1, -1);
    drain("int8_drain");
    check("overrun_clear", 128'(o_overrun), 128'd0);

    // INT4_VSQ: per-row shift, no MAX pass; overrun pulse 5 cycles in.
    i_mode = `INT4_VSQ;
    for (int r = 0; r < 16; r++) begin
      if (r % 2 == 0) begin
        ent[0] = 100; ent[1] = -100; ent[2] = 50; ent[3] = 7;
        qv[0]  = 6;   qv[1]  = -6;   qv[2]  = 3;  qv[3]  = 0;
        set_row(r, 8'd4);
      end else begin
        set_row(r, 8'd0);
      end
    end
    burst(1, 0, 0, 4, -1);
    check("overrun_set", 128'(o_overrun), 128'd1);
    for (int r = 0; r < 16; r++) begin
      if (r % 3 == 0) begin
        ent[0] = -8388608; ent[1] = 5;
        qv[0]  = -7;       qv[1]  = 0;
        set_row(r, 8'd20);
      end else if (r % 3 == 1) begin
        ent[0] = 7; ent[1] = -8; ent[2] = 3;
        qv[0]  = 4; qv[1]  = -4; qv[2]  = 2;
        set_row(r, 8'd1);
      end else begin
        ent[0] = 7; ent[1] = -7; ent[2] = -6;
        qv[0]  = 7; qv[1]  = -7; qv[2]  = -6;
        set_row(r, 8'd0);
      end
    end
    burst(1, 1, 1, -1, -1);
    drain("vsq_drain");
    check("overrun_sticky", 128'(o_overrun), 128'd1);

    // INT8: MAX -300 -> shift 2, then reset with CALC row 7.
    i_mode = `INT8;
    zero_rows();
    ent[0] = -300; set_row(0, 8'd0);
    burst(0, 0, 0, -1, -1);
    zero_rows();
    burst(0, 1, 0, -1, -1);
    for (int r = 0; r < 16; r++) begin
      ent[0] = 300; ent[1] = -301; ent[2] = 2; ent[3] = 1;
      qv[0]  = 75;  qv[1]  = -75;  qv[2]  = 1; qv[3]  = 0;
      set_row(r, 8'd2);
    end
    burst(1, 0, 0, -1, 7);
    check_outputs_zero("midrst");
    check("midrst_queue", 128'(sb.size()), 128'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // INT4 after reset: must run a MAX pass first (max 40 -> shift 3).
    i_mode = `INT4;
    zero_rows();
    ent[15] = 40; set_row(3, 8'd0);
    nv0 = n_valid;
    burst(0, 0, 0, -1, -1);
    zero_rows();
    burst(0, 1, 0, -1, -1);
    check("int4_max_quiet", 128'(n_valid - nv0), 128'd0);
    for (int r = 0; r < 16; r++) begin
      ent[0] = 40; ent[1] = -40; ent[2] = 20; ent[3] = -3;
      ent[4] = 8388607; ent[15] = -8388608;
      qv[0]  = 5;  qv[1]  = -5;  qv[2]  = 3;  qv[3]  = 0;
      qv[4]  = 7;  qv[15] = -7;
      set_row(r, 8'd3);
    end
    burst(1, 0, 0, -1, -1);
    burst(1, 1, 1, -1, -1);
    drain("int4_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
